// File: rtl/ysyx_22041207_pkg.sv
// ysyx_22041207_pkg: shared fetch-unit widths, reset vector, fetch-entry record and redirect-source encoding
package ysyx_22041207_pkg;
  localparam int DEF_XLEN = 64;
  localparam int DEF_ILEN = 32;
  localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;
  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_ILEN-1:0] inst;
  } fetch_entry_t;
  typedef enum logic [1:0] {BR, JALR, TRAP} redir_src_e;
endpackage

// File: rtl/ysyx_22041207_fifo.sv
// ysyx_22041207_fifo: DEPTH-entry flushable queue; clk/rst_n, flush, push/din, pop, valid/dout (zero while empty), count
module ysyx_22041207_fifo #(
  parameter int W = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic                       valid,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  assign count = cnt;
  assign valid = cnt != '0;
  assign dout = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && !flush && cnt == (AW+1)'(DEPTH)));
endmodule

// File: rtl/ysyx_22041207_ifu.sv
// ysyx_22041207_ifu: fetch unit; redirects (ex_br/ex_jalr/trap) pick fetch_pc, imem_req/imem_rsp carry one outstanding fetch, inst_valid/inst_ready/inst_o/pc_o drain the fetch queue to decode
module ysyx_22041207_ifu
  import ysyx_22041207_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC[XLEN-1:0],
  parameter int DEPTH = 4,
  parameter int ILEN = DEF_ILEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_br_taken,
  input  logic [XLEN-1:0] ex_br_target,
  input  logic            ex_jalr,
  input  logic [XLEN-1:0] ex_jalr_base,
  input  logic [XLEN-1:0] ex_jalr_off,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] csr_mtvec,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] fetch_pc, req_pc, jalr_sum, target;
  logic outstanding, squash, redirect, req_fire, rsp_hit, push, pop;
  logic [CW-1:0] count;
  redir_src_e src;
  always_comb begin
    redirect = ex_br_taken | ex_jalr | trap_valid;
    src = ex_br_taken ? BR : ex_jalr ? JALR : TRAP;
    jalr_sum = ex_jalr_base + ex_jalr_off;
    target = src == BR ? ex_br_target : src == JALR ? {jalr_sum[XLEN-1:1], 1'b0} : csr_mtvec;
    imem_req_valid = rst_n & !redirect & !outstanding & (count < CW'(DEPTH));
    imem_req_addr = fetch_pc;
    req_fire = imem_req_valid & imem_req_ready;
    rsp_hit = imem_rsp_valid & outstanding;
    push = rsp_hit & !squash & !redirect;
    pop = inst_valid & inst_ready;
  end
  // a redirect while waiting marks the in-flight response for dropping, unless it lands this very cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc <= '0;
      outstanding <= 1'b0;
      squash <= 1'b0;
    end else begin
      fetch_pc <= redirect ? target : req_fire ? fetch_pc + XLEN'(4) : fetch_pc;
      if (req_fire) req_pc <= fetch_pc;
      outstanding <= req_fire | (outstanding & !rsp_hit);
      squash <= redirect ? outstanding & !rsp_hit : squash & !rsp_hit;
    end
  end
  ysyx_22041207_fifo #(.W(XLEN + ILEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(redirect),
    .push(push),
    .din({req_pc, imem_rsp_data}),
    .pop(pop),
    .valid(inst_valid),
    .dout({pc_o, inst_o}),
    .count(count)
  );
endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
// tb_ysyx_22041207_ifu: redirect table, directed fetch sequences and random traffic against a queue-based fetch model
module tb_ysyx_22041207_ifu;
  import ysyx_22041207_pkg::*;
  localparam int DEPTH = 4;
  localparam logic [63:0] RPC = 64'h8000_0000;
  logic clk = 0, rst_n = 0;
  logic ex_br_taken = 0, ex_jalr = 0, trap_valid = 0, imem_req_ready = 0, imem_rsp_valid = 0, inst_ready = 0;
  logic [63:0] ex_br_target = 0, ex_jalr_base = 0, ex_jalr_off = 0, csr_mtvec = 0, imem_req_addr, pc_o;
  logic imem_req_valid, inst_valid;
  logic [31:0] imem_rsp_data = 0, inst_o;
  ysyx_22041207_ifu #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .ex_jalr(ex_jalr), .ex_jalr_base(ex_jalr_base), .ex_jalr_off(ex_jalr_off),
    .trap_valid(trap_valid), .csr_mtvec(csr_mtvec),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_o(inst_o), .pc_o(pc_o)
  );
  always #5 clk = ~clk;
  fetch_entry_t q[$];
  logic [63:0] m_pc = RPC, m_req_pc = 0;
  logic m_inflight = 0, m_squash = 0;
  int lat = 0, lat_min = 0, lat_max = 0, cyc = 0, n_acc = 0;
  bit spur = 0, acc = 0;
  logic d_rdy = 0, d_irdy = 0, d_br = 0, d_jalr = 0, d_trap = 0, d_force_rsp = 0;
  logic [63:0] d_brt = 0, d_base = 0, d_off = 0, d_mtvec = 0;
  int tests = 0, fails = 0;
  typedef struct {
    logic br, jalr, trap;
    logic [63:0] brt, base, off, mtvec, exp;
  } rv_t;
  rv_t tab[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [63:0] tgt();
    return d_br ? d_brt : d_jalr ? ((d_base + d_off) & ~64'h1) : d_mtvec;
  endfunction
  task automatic idle_inputs();
    {ex_br_taken, ex_jalr, trap_valid, imem_req_ready, imem_rsp_valid} = '0;
    {d_br, d_jalr, d_trap, d_rdy, d_force_rsp} = '0;
  endtask
  task automatic step();
    logic redir, exp_req;
    @(negedge clk);
    cyc++;
    ex_br_taken = d_br; ex_jalr = d_jalr; trap_valid = d_trap;
    ex_br_target = d_brt; ex_jalr_base = d_base; ex_jalr_off = d_off; csr_mtvec = d_mtvec;
    imem_req_ready = d_rdy; inst_ready = d_irdy;
    imem_rsp_data = $urandom;
    if (m_inflight && lat == 0) imem_rsp_valid = 1;
    else begin
      imem_rsp_valid = d_force_rsp || (spur && !m_inflight && $urandom_range(7) == 0);
      if (m_inflight) lat--;
    end
    #1;
    redir = d_br | d_jalr | d_trap;
    exp_req = !redir && !m_inflight && q.size() < DEPTH;
    chk("req_valid", imem_req_valid, exp_req);
    if (exp_req) chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", inst_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("pc_o", pc_o, q[0].pc);
      chk("inst_o", inst_o, q[0].inst);
      if (d_irdy) void'(q.pop_front());
    end
    acc = exp_req && d_rdy;
    if (imem_rsp_valid && m_inflight) begin
      if (!redir && !m_squash) q.push_back('{pc: m_req_pc, inst: imem_rsp_data});
      m_inflight = 0;
      m_squash = 0;
    end
    if (redir) begin
      q.delete();
      m_pc = tgt();
      if (m_inflight) m_squash = 1;
    end
    if (acc) begin
      m_inflight = 1;
      m_req_pc = m_pc;
      m_pc += 64'd4;
      lat = $urandom_range(lat_max, lat_min);
      n_acc++;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    idle_inputs();
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_o", inst_o, 0);
    chk("rst_pc_o", pc_o, 0);
    q.delete();
    m_pc = RPC; m_inflight = 0; m_squash = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    logic [63:0] addrs[$];
    int first_acc, n0;
    bit seen;
    tab[0] = '{1, 0, 0, 64'h8000_0100, 0, 0, 0, 64'h8000_0100};
    tab[1] = '{0, 1, 0, 0, 64'h8000_1003, 0, 0, 64'h8000_1002};
    tab[2] = '{0, 0, 1, 0, 0, 0, 64'h8000_0006, 64'h8000_0006};
    tab[3] = '{1, 1, 1, 64'h8000_0100, 64'h1000, 4, 64'h2000, 64'h8000_0100};
    tab[4] = '{0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 3, 64'h3000, 64'h2};
    tab[5] = '{0, 1, 0, 0, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h7FFF_FFF8};
    tab[6] = '{1, 0, 1, 64'h8000_0202, 0, 0, 64'h4000, 64'h8000_0202};
    // reset release, zero-wait memory, decode stalled: 4 fetches fill the queue then stop
    do_reset();
    d_rdy = 1; d_irdy = 0; lat_min = 0; lat_max = 0; first_acc = -1; seen = 0; n0 = n_acc;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc) begin
        addrs.push_back(imem_req_addr);
        if (first_acc < 0) first_acc = cyc;
      end
      if (inst_valid && !seen) begin
        seen = 1;
        chk("first_iv_latency", cyc - first_acc, 2);
        chk("first_pc_o", pc_o, RPC);
      end
    end
    chk("fill_count", n_acc - n0, DEPTH);
    chk("addr0", addrs.size() > 0 ? addrs[0] : 0, 64'h8000_0000);
    chk("addr1", addrs.size() > 1 ? addrs[1] : 0, 64'h8000_0004);
    chk("addr2", addrs.size() > 2 ? addrs[2] : 0, 64'h8000_0008);
    chk("full_req_valid", imem_req_valid, 0);
    d_irdy = 1; n0 = n_acc;
    for (int i = 0; i < 5 && n_acc == n0; i++) step();
    chk("refill_after_pop", n_acc - n0, 1);
    // redirect table, each preceded by 3 stalled cycles with ready low
    do_reset();
    d_irdy = 1;
    foreach (tab[i]) begin
      d_rdy = 0;
      for (int k = 0; k < 3; k++) begin
        step();
        chk("stall_addr", imem_req_addr, i == 0 ? RPC : tab[i-1].exp);
      end
      d_br = tab[i].br; d_jalr = tab[i].jalr; d_trap = tab[i].trap;
      d_brt = tab[i].brt; d_base = tab[i].base; d_off = tab[i].off; d_mtvec = tab[i].mtvec;
      step();
      chk("redir_req_valid", imem_req_valid, 0);
      {d_br, d_jalr, d_trap} = '0;
      step();
      chk("tab_req_valid", imem_req_valid, 1);
      chk("tab_addr", imem_req_addr, tab[i].exp);
    end
    // jalr while a request is outstanding squashes the in-flight response
    do_reset();
    d_rdy = 1; d_irdy = 0; lat_min = 2; lat_max = 2; n0 = n_acc;
    for (int i = 0; i < 5 && n_acc == n0; i++) step();
    chk("jalr_pre_accept", n_acc - n0, 1);
    d_jalr = 1; d_base = 64'h8000_1003; d_off = 0;
    step();
    d_jalr = 0; lat_min = 0; lat_max = 0; n0 = n_acc; seen = 0;
    for (int i = 0; i < 10 && n_acc == n0; i++) step();
    chk("jalr_reissue", n_acc - n0, 1);
    chk("jalr_addr", imem_req_addr, 64'h8000_1002);
    for (int i = 0; i < 6 && !inst_valid; i++) step();
    chk("jalr_iv", inst_valid, 1);
    chk("jalr_pc_o", pc_o, 64'h8000_1002);
    // reset pulsed mid-request, late response after release is ignored
    lat_min = 5; lat_max = 5; n0 = n_acc;
    for (int i = 0; i < 5 && n_acc == n0; i++) step();
    do_reset();
    d_rdy = 1; d_irdy = 0; lat_min = 0; lat_max = 0; d_force_rsp = 1;
    step();
    chk("rst_restart_valid", imem_req_valid, 1);
    chk("rst_restart_addr", imem_req_addr, RPC);
    d_force_rsp = 0;
    for (int i = 0; i < 6 && !inst_valid; i++) step();
    chk("rst_first_pc", pc_o, RPC);
    // random traffic against the model
    do_reset();
    spur = 1; lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      d_rdy = $urandom_range(3) != 0;
      d_irdy = $urandom_range(1);
      {d_br, d_jalr, d_trap} = '0;
      if ($urandom_range(11) == 0) begin
        d_br = $urandom_range(1);
        d_jalr = $urandom_range(1);
        d_trap = !(d_br || d_jalr) || $urandom_range(1);
      end
      d_brt = {$urandom, $urandom}; d_base = {$urandom, $urandom};
      d_off = {{32{1'b0}}, $urandom}; d_mtvec = {$urandom, $urandom};
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
